// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the mem_responder line-memory model.
// The LFSR constants are only used when MEM_RESP_RANDLAT_EN is defined.
package mem_resp_pkg;

  localparam int DATA_W = 128;
  localparam int ADDR_W = 28;
  // Counter must hold LATENCY-1 plus up to 7 cycles of jitter.
  localparam int CNT_W  = 9;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

endpackage

// File: rtl/mem_responder_if.sv
// Line memory bus between the L2 cache (master) and the memory responder (slave).
interface mem_responder_if;
  import mem_resp_pkg::*;

  // Handshake: the master raises exactly one of mem_read/mem_write and holds it,
  // with mem_addr/mem_wdata, until it sees mem_ready, a one-cycle registered
  // pulse; mem_rdata is valid only in that cycle. Dropping the request early aborts.
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_ready, mem_rdata
  );

endinterface

// File: rtl/mem_resp_lfsr.sv
// Latency jitter source: 16-bit Fibonacci LFSR stepped once per accepted request.
// Instantiated by mem_responder only when MEM_RESP_RANDLAT_EN is defined.
module mem_resp_lfsr
  import mem_resp_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       adv,
  output logic [2:0] jitter
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (adv) lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= lfsr_d;
  end

  // Jitter for a request comes from the value present when it is accepted.
  assign jitter = lfsr_q[2:0];

endmodule

// File: rtl/mem_responder.sv
// Line-addressed main-memory responder: one request at a time, fixed LATENCY.
// Optional MEM_RESP_RANDLAT_EN adds 0..7 cycles of LFSR jitter per request.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int LATENCY = 8,
  parameter int DEPTH_W = 10
) (
  input  logic             clk,
  input  logic             mem_reset_n,
  mem_responder_if.slave   bus,
  output state_e           dbg_state
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DEPTH_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  op_e                op_q, op_d;
  logic               ready_q, ready_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               mem_we;
  logic               req_valid;
  logic               active_req;
  logic [2:0]         jitter;

  logic [DATA_W-1:0]  mem_q [2**DEPTH_W];

  // Lines above the array depth alias by truncation.
  logic [ADDR_W-DEPTH_W-1:0] unused_addr_hi;
  assign unused_addr_hi = bus.mem_addr[ADDR_W-1:DEPTH_W];

  assign req_valid  = bus.mem_read ^ bus.mem_write;
  assign active_req = (op_q == OP_WRITE) ? bus.mem_write : bus.mem_read;

`ifdef MEM_RESP_RANDLAT_EN
  mem_resp_lfsr u_lfsr (
    .clk    (clk),
    .rst_n  (mem_reset_n),
    .adv    (req_valid && (state_q == IDLE)),
    .jitter (jitter)
  );
`else
  assign jitter = 3'd0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    op_d    = op_q;
    ready_d = 1'b0;
    rdata_d = rdata_q;
    mem_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Both request lines high is a protocol violation and is ignored.
        if (req_valid) begin
          idx_d   = bus.mem_addr[DEPTH_W-1:0];
          wdata_d = bus.mem_wdata;
          op_d    = bus.mem_write ? OP_WRITE : OP_READ;
          cnt_d   = CNT_W'(LATENCY - 1) + CNT_W'(jitter);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!active_req) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = RESP;
          ready_d = 1'b1;
          if (op_q == OP_WRITE) mem_we  = 1'b1;
          else                  rdata_d = mem_q[idx_q];
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge mem_reset_n) begin
    if (!mem_reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      op_q    <= OP_READ;
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      op_q    <= op_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx_q] <= wdata_q;
  end

  assign bus.mem_ready = ready_q;
  assign bus.mem_rdata = rdata_q;
  assign dbg_state     = state_q;

endmodule
